// File: rtl/adc_pkg.sv
// adc_pkg: channel codes, frame length and result decode shared by the ADC128S SPI model
package adc_pkg;
  typedef logic [2:0] ch_t;
  localparam ch_t CH_LFT = 3'd0;
  localparam ch_t CH_RGHT = 3'd4;
  localparam ch_t CH_STEER = 3'd5;
  localparam ch_t CH_BATT = 3'd6;
  localparam int FRAME_BITS = 16;
  localparam logic [11:0] UNUSED_VAL = 12'h000;
  function automatic logic [11:0] ch_sel(input ch_t c, input logic [11:0] l, input logic [11:0] r,
                                         input logic [11:0] s, input logic [11:0] b);
    return c == CH_LFT ? l : c == CH_RGHT ? r : c == CH_STEER ? s : c == CH_BATT ? b : UNUSED_VAL;
  endfunction
endpackage

// File: rtl/adc_spi_sync.sv
// adc_spi_sync: 2-flop synchronizers for SS_n/SCLK/MOSI with edge pulses on the synchronized copies
module adc_spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_ss_n,
  input  logic i_sclk,
  input  logic i_mosi,
  output logic o_ss_n,
  output logic o_mosi,
  output logic o_ss_fall,
  output logic o_ss_rise,
  output logic o_sclk_rise,
  output logic o_sclk_fall
);
  logic [2:0] r_ss, r_sclk;
  logic [1:0] r_mosi;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss <= 3'b111;
      r_sclk <= 3'b000;
      r_mosi <= 2'b00;
    end else begin
      r_ss <= {r_ss[1:0], i_ss_n};
      r_sclk <= {r_sclk[1:0], i_sclk};
      r_mosi <= {r_mosi[0], i_mosi};
    end
  end
  assign o_ss_n = r_ss[1];
  assign o_mosi = r_mosi[1];
  assign o_ss_fall = r_ss[2] & ~r_ss[1];
  assign o_ss_rise = ~r_ss[2] & r_ss[1];
  assign o_sclk_rise = ~r_sclk[2] & r_sclk[1];
  assign o_sclk_fall = r_sclk[2] & ~r_sclk[1];
endmodule

// File: rtl/adc128s_spi_model.sv
// adc128s_spi_model: 8-channel 12-bit SPI A2D slave model; ADC_MISO_TRISTATE_EN floats MISO while deselected
module adc128s_spi_model
  import adc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);
  logic w_ss_n, w_mosi, w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_sel, w_full;
  logic [15:0] r_rx, r_tx;
  logic [4:0] r_cnt;
  ch_t r_ptr;
  adc_spi_sync u_sync (
    .clk(clk), .rst(rst), .i_ss_n(SS_n), .i_sclk(SCLK), .i_mosi(MOSI),
    .o_ss_n(w_ss_n), .o_mosi(w_mosi), .o_ss_fall(w_ss_fall), .o_ss_rise(w_ss_rise),
    .o_sclk_rise(w_sclk_rise), .o_sclk_fall(w_sclk_fall)
  );
  assign w_sel = ~w_ss_n;
  assign w_full = r_cnt == 5'(FRAME_BITS);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx <= '0;
      r_tx <= '0;
      r_cnt <= '0;
      r_ptr <= CH_LFT;
    end else begin
      if (w_ss_fall) begin
        r_tx <= {4'b0000, ch_sel(r_ptr, ld_cell_lft, ld_cell_rght, steerPot, batt)};
        r_cnt <= '0;
      end else if (w_sel) begin
        if (w_sclk_rise) begin
          r_rx <= {r_rx[14:0], w_mosi};
          r_cnt <= w_full ? r_cnt : r_cnt + 5'd1;
        end
        if (w_sclk_fall) r_tx <= {r_tx[14:0], 1'b0};
      end
      if (w_ss_rise && w_full) r_ptr <= r_rx[13:11];
    end
  end
`ifdef ADC_MISO_TRISTATE_EN
  assign MISO = w_sel ? r_tx[15] : 1'bz;
`else
  assign MISO = w_sel & r_tx[15];
`endif
endmodule

// File: tb/tb_adc128s_spi_model.sv
// tb_adc128s_spi_model: SPI master driver, scoreboard queue and pin-level MISO monitor
module tb_adc128s_spi_model;
  logic clk = 0, rst = 1, SS_n = 1, SCLK = 0, MOSI = 0;
  wire MISO;
  logic [11:0] lft = 12'h400, rght = 12'h3A5, steer = 12'h800, batt = 12'hFFF;
  int errors = 0, checks = 0, nb = 0;
  logic [15:0] expq[$];
  logic [31:0] acc = 0, e;
  logic [2:0] ptr_m = 3'd0;
`ifdef ADC_MISO_TRISTATE_EN
  localparam logic IDLE = 1'bz;
`else
  localparam logic IDLE = 1'b0;
`endif
  always #5 clk = ~clk;
  adc128s_spi_model dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ld_cell_lft(lft), .ld_cell_rght(rght), .steerPot(steer), .batt(batt)
  );
  function automatic logic [11:0] ref_val(input logic [2:0] c);
    case (c)
      3'd0: return lft;
      3'd4: return rght;
      3'd5: return steer;
      3'd6: return batt;
      default: return 12'h000;
    endcase
  endfunction
  function automatic logic [15:0] aw(input logic [2:0] c);
    return {2'b00, c, 11'h000};
  endfunction
  task automatic chk_idle(input string nm);
    checks++;
    if (MISO !== IDLE) begin
      errors++;
      $display("FAIL %s: MISO=%b expected %b", nm, MISO, IDLE);
    end
  endtask
  task automatic frame(input logic [15:0] w, input int n, input logic chg = 1'b0, input logic [11:0] nv = 12'h0);
    logic [15:0] l;
    if (n >= 16) expq.push_back({4'b0000, ref_val(ptr_m)});
    SS_n = 0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      MOSI = i < 16 ? w[15-i] : 1'b0;
      repeat (16) @(negedge clk);
      SCLK = 1;
      repeat (16) @(negedge clk);
      SCLK = 0;
      if (chg && i == 3) batt = nv;
    end
    repeat (8) @(negedge clk);
    SS_n = 1;
    repeat (8) @(negedge clk);
    chk_idle("idle_after_frame");
    if (n >= 16) begin
      l = w << (n - 16);
      ptr_m = l[13:11];
    end
  endtask
  always @(negedge SS_n) begin
    nb = 0;
    acc = 0;
  end
  always @(posedge SCLK) if (!SS_n) begin
    acc = {acc[30:0], MISO};
    nb++;
  end
  always @(posedge SS_n) if (nb >= 16) begin
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL frame_unexpected: got %h with nothing expected", acc);
    end else begin
      e = {16'h0, expq.pop_front()} << (nb - 16);
      if (acc !== e) begin
        errors++;
        $display("FAIL frame_word: MISO bits=%h expected %h (%0d sclks)", acc, e, nb);
      end
    end
  end
  initial begin
    repeat (4) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    chk_idle("reset_idle");
    frame(16'h0000, 16);
    frame(aw(3'd6), 16);
    frame(aw(3'd5), 16);
    frame(aw(3'd4), 16);
    frame(aw(3'd2), 16);
    frame(aw(3'd6), 8);
    frame(aw(3'd6), 16);
    frame(aw(3'd0), 16, 1'b1, 12'h123);
    frame(aw(3'd6), 16);
    frame(aw(3'd5), 18);
    frame(aw(3'd5), 16);
    SS_n = 0;
    repeat (8) @(negedge clk);
    repeat (3) begin
      SCLK = 1;
      repeat (16) @(negedge clk);
      SCLK = 0;
      repeat (16) @(negedge clk);
    end
    rst = 1;
    #1 chk_idle("rst_mid_frame");
    repeat (2) @(negedge clk);
    SS_n = 1;
    repeat (4) @(negedge clk);
    rst = 0;
    ptr_m = 3'd0;
    repeat (8) @(negedge clk);
    chk_idle("idle_after_rst");
    frame(aw(3'd4), 16);
    for (int k = 0; k < 24; k++) begin
      int r, n;
      lft = 12'($urandom);
      rght = 12'($urandom);
      steer = 12'($urandom);
      batt = 12'($urandom);
      r = $urandom_range(0, 9);
      n = r < 6 ? 16 : r < 8 ? $urandom_range(1, 15) : 16 + $urandom_range(1, 3);
      frame(16'($urandom), n);
    end
    frame(16'h0000, 16);
    repeat (20) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
